// File: rtl/uart_rx_deserializer_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default bit period.
// The default bit period is also used by the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 10416;  // 100 MHz system clock, 9600 baud

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Serial line in, received byte and status strobes out.
// The master side drives the line; the slave side is the deserializer.
interface uart_rx_deserializer_if;
    import uart_pkg::*;

    logic                      rx_i;
    logic [UART_DATA_BITS-1:0] rx_data_o;
    logic                      rx_pulse_o;
    logic                      frame_err_o;
    logic                      busy_o;

    modport master (
        output rx_i,
        input  rx_data_o,
        input  rx_pulse_o,
        input  frame_err_o,
        input  busy_o
    );

    modport slave (
        input  rx_i,
        output rx_data_o,
        output rx_pulse_o,
        output frame_err_o,
        output busy_o
    );

endinterface

// File: rtl/uart_rx_deserializer_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, one independent chain per bit.
// The reset value is a parameter so that idle-high lines come out of reset inactive.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_meta[gi] <= RESET_VAL[gi];
                r_sync[gi] <= RESET_VAL[gi];
            end else begin
                r_meta[gi] <= d_i[gi];
                r_sync[gi] <= r_meta[gi];
            end
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: start-bit validation, mid-bit sampling of 8 data bits (LSB first),
// and stop-bit check. A good frame gives a one-cycle rx_pulse_o; a bad stop bit gives frame_err_o.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    uart_rx_deserializer_if.slave   rx_if
);

    localparam int                CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]     CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]     CNT_HALF = CW'(HALF_BIT - 1);
    localparam logic [2:0]        IDX_LAST = 3'(UART_DATA_BITS - 1);

    logic                       w_rx_sync;

    uart_rx_state_t             r_state;
    logic [CW-1:0]              r_cnt;
    logic [2:0]                 r_idx;
    logic [UART_DATA_BITS-1:0]  r_sh;
    logic [UART_DATA_BITS-1:0]  r_data;
    logic                       r_pulse;
    logic                       r_ferr;
    logic                       r_busy;

    uart_rx_state_t             w_state_next;
    logic [CW-1:0]              w_cnt_next;
    logic [2:0]                 w_idx_next;
    logic [UART_DATA_BITS-1:0]  w_sh_next;
    logic [UART_DATA_BITS-1:0]  w_data_next;
    logic                       w_pulse_next;
    logic                       w_ferr_next;
    logic                       w_busy_next;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_if.rx_i),
        .q_o   (w_rx_sync)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_sh_next    = r_sh;
        w_data_next  = r_data;
        w_pulse_next = 1'b0;
        w_ferr_next  = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rx_sync) begin
                    w_state_next = START;
                    w_cnt_next   = '0;
                end
            end

            START: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == CNT_HALF) begin
                    w_cnt_next = '0;
                    if (!w_rx_sync) begin
                        w_state_next = DATA;
                        w_idx_next   = '0;
                    end else begin
                        // Line went high again before mid-bit: treat as a glitch.
                        w_state_next = IDLE;
                    end
                end
            end

            DATA: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next = '0;
                    w_sh_next  = {w_rx_sync, r_sh[UART_DATA_BITS-1:1]};
                    if (r_idx == IDX_LAST) begin
                        w_state_next = STOP;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end

            STOP: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next = '0;
                    if (w_rx_sync) begin
                        w_data_next  = r_sh;
                        w_pulse_next = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        // A low stop bit may be a break; wait for the line to idle first.
                        w_ferr_next  = 1'b1;
                        w_state_next = WAIT_IDLE;
                    end
                end
            end

            WAIT_IDLE: begin
                if (w_rx_sync) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase

        w_busy_next = (w_state_next != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sh    <= '0;
            r_data  <= '0;
            r_pulse <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_sh    <= w_sh_next;
            r_data  <= w_data_next;
            r_pulse <= w_pulse_next;
            r_ferr  <= w_ferr_next;
            r_busy  <= w_busy_next;
        end
    end

    assign rx_if.rx_data_o   = r_data;
    assign rx_if.rx_pulse_o  = r_pulse;
    assign rx_if.frame_err_o = r_ferr;
    assign rx_if.busy_o      = r_busy;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: a serial sender pushes the expected strobe
// (kind, byte, cycle) for each frame; a monitor pops and compares whenever a strobe appears.
module tb_uart_rx_deserializer;

    localparam int CPB = 16;
    localparam int HB  = CPB / 2;
    localparam int LAT = 2 + HB + 9 * CPB;  // first low edge -> strobe edge

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_deserializer_if rx_bus ();

    uart_rx_deserializer #(
        .CLKS_PER_BIT (CPB),
        .HALF_BIT     (HB)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .rx_if (rx_bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks  = 0;
    int         n_pass    = 0;
    logic [7:0] last_good = 8'h00;
    bit         prev_strobe = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Cycle offset of the start of frame bit i; fast mode gives a 15.5-clock bit.
    function automatic int bound(input int i, input bit fast);
        return fast ? (i * 31) / 2 : i * CPB;
    endfunction

    // Must be called at a negedge; leaves the line at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input bit stop_val, input bit fast,
                              input bit expect_it);
        int        k;
        logic [9:0] bits;
        exp_t      e;
        k    = cyc + 1;
        bits = {stop_val, b, 1'b0};
        if (expect_it) begin
            e.is_err = !stop_val;
            e.data   = stop_val ? b : last_good;
            e.at     = k + LAT;
            exp_q.push_back(e);
            if (stop_val) last_good = b;
        end
        $display("send byte=%02h stop=%0d fast=%0d expect=%0d edge=%0d", b, stop_val, fast,
                 expect_it, k);
        for (int i = 0; i < 10; i++) begin
            rx_bus.rx_i = bits[i];
            repeat (bound(i + 1, fast) - bound(i, fast)) @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   strobe;
        if (rst) begin
            prev_strobe = 1'b0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                e = exp_q.pop_front();
                check("strobe_missing", 0, 1);
            end
            strobe = rx_bus.rx_pulse_o | rx_bus.frame_err_o;
            if (strobe) begin
                check("pulse_err_exclusive", rx_bus.rx_pulse_o & rx_bus.frame_err_o, 0);
                check("strobe_not_consecutive", prev_strobe, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind_err", rx_bus.frame_err_o, e.is_err);
                    check("rx_data", rx_bus.rx_data_o, e.data);
                    check("strobe_cycle", cyc, e.at);
                    $display("strobe err=%0d data=%02h cycle=%0d", rx_bus.frame_err_o,
                             rx_bus.rx_data_o, cyc);
                end
            end
            prev_strobe = strobe;
        end
    end

    initial begin
        int k;
        int waited;
        logic [7:0] b;
        rx_bus.rx_i = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_data", rx_bus.rx_data_o, 8'h00);
        check("reset_pulse", rx_bus.rx_pulse_o, 0);
        check("reset_ferr", rx_bus.frame_err_o, 0);
        check("reset_busy", rx_bus.busy_o, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Ideal single frame
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        check("hold_data_a5", rx_bus.rx_data_o, 8'hA5);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);

        // Five-clock low glitch on an idle line
        k = cyc + 1;
        $display("glitch 5 clocks edge=%0d", k);
        rx_bus.rx_i = 1'b0;
        repeat (5) @(negedge clk);
        rx_bus.rx_i = 1'b1;
        check("glitch_busy_high", rx_bus.busy_o, 1);
        while (cyc < k + 9) @(negedge clk);
        check("glitch_busy_before_mid", rx_bus.busy_o, 1);
        @(negedge clk);
        check("glitch_busy_falls", rx_bus.busy_o, 0);
        check("glitch_data_kept", rx_bus.rx_data_o, last_good);
        repeat (20) @(negedge clk);

        // Low stop bit followed by a long break
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (40 * CPB) @(negedge clk);
        check("break_busy_held", rx_bus.busy_o, 1);
        check("break_data_kept", rx_bus.rx_data_o, last_good);
        rx_bus.rx_i = 1'b1;
        waited = 0;
        while (rx_bus.busy_o && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("break_busy_release", rx_bus.busy_o, 0);
        repeat (20) @(negedge clk);
        send_frame(8'h55, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);

        // Reset during data bit 4; held until the interrupted frame has ended
        fork
            send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
            begin
                repeat (85) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("midreset_rx_data", rx_bus.rx_data_o, 8'h00);
                check("midreset_pulse", rx_bus.rx_pulse_o, 0);
                check("midreset_ferr", rx_bus.frame_err_o, 0);
                check("midreset_busy", rx_bus.busy_o, 0);
            end
        join
        last_good = 8'h00;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);

        // Sender 3 % fast
        send_frame(8'hC3, 1'b1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);

        // Random bytes with random gaps (some back-to-back)
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1, 1'b0, 1'b1);
            if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 30)) @(negedge clk);
        end

        repeat (200) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Serial-to-parallel receive front end of the UART peripheral. Synchronises the asynchronous `rx_i` line, detects and validates the start bit, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. On a good frame it presents the byte and a one-cycle `rx_pulse_o`. That pulse drives the reception FSM's `rx_pulse_i`, which writes the byte into the data register and sets `new_rx` in the control register.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 10416 (100 MHz / 9600 baud): clocks per bit; legal range ≥ 4.
- `HALF_BIT`, default `CLKS_PER_BIT/2` (floor): start-bit validation delay.

Ports:
- `clk_i`  in  1  system clock; single clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `rx_i`  in  1  asynchronous serial line; idles high.
- `rx_data_o`  out  8  last correctly received byte.
- `rx_pulse_o`  out  1  one-cycle strobe: `rx_data_o` is valid and new.
- `frame_err_o`  out  1  one-cycle strobe: stop bit sampled low.
- `busy_o`  out  1  high whenever the state is not IDLE.

## Operation
- Two-flop synchroniser on `rx_i` produces `rx_sync`. Both flops reset to 1.
- Bit counter `cnt` has width `$clog2(CLKS_PER_BIT)`. Bit index `idx` has width 3. Shift register `sh` is 8 bits; each new sample enters at bit 7 and the register shifts right, so after 8 samples bit 0 holds the first bit received.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on `rx_sync==0`, go to START with `cnt<=0`.
  - START: increment `cnt`. At `cnt==HALF_BIT-1`, sample `rx_sync`:
    - 0: go to DATA with `cnt<=0`, `idx<=0`.
    - 1: glitch; return to IDLE with no output.
  - DATA: increment `cnt`. At `cnt==CLKS_PER_BIT-1`, shift in `rx_sync` and set `cnt<=0`.
    - `idx==7`: go to STOP.
    - Otherwise: `idx++`.
  - STOP: at `cnt==CLKS_PER_BIT-1`, sample `rx_sync`:
    - 1: `rx_data_o<=sh`, `rx_pulse_o<=1`, go to IDLE.
    - 0: `frame_err_o<=1`, `rx_data_o` unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_sync==1`, then go to IDLE. This prevents a break or stuck-low line from retriggering frames.
- All outputs are registered. `rx_pulse_o` and `frame_err_o` are never high in the same cycle and never high for two consecutive cycles.
- No parity bit; exactly 1 stop bit.
- Back-to-back frames: IDLE is entered on the STOP-sample edge, so a start bit immediately following the stop bit's mid-point is detected. No idle gap is needed beyond the second half of the stop bit.
- Reset mid-frame: on the next edge, state returns to IDLE, `cnt`, `idx` and `sh` go to 0, and no strobe is issued. A frame already in progress at reset release is treated as line activity: if `rx_sync` is low, it is seen as a start bit, validated at mid-bit, and otherwise discarded as a glitch.

## Timing
- Reset values:
  - `rx_data_o=8'h00`, `rx_pulse_o=0`, `frame_err_o=0`, `busy_o=0`.
  - Internal: state IDLE, `cnt=0`, `idx=0`, `sh=0`; synchroniser flops at 1.
- Latency: let edge k be the first rising edge at which `rx_i` is low.
  - `rx_sync` is low after edge k+1.
  - START is entered at edge k+2.
  - Start validated at edge k+2+HALF_BIT.
  - Data bit n sampled at edge k+2+HALF_BIT+(n+1)·CLKS_PER_BIT.
  - Stop sampled at edge k+2+HALF_BIT+9·CLKS_PER_BIT. `rx_pulse_o` or `frame_err_o` is high for the one cycle following that edge.
- For `CLKS_PER_BIT=16`: total latency is 2+8+144 = 154 clocks.
- A low glitch shorter than HALF_BIT cycles (as seen at `rx_sync`) produces no strobe, and `busy_o` falls at edge k+2+HALF_BIT.
- Tolerated baud mismatch: ±4 % (mid-bit sampling across 10 bits).

## Structure
- Package `uart_pkg` holds:
  - `typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE}`;
  - `localparam UART_DATA_BITS = 8`;
  - default `CLKS_PER_BIT`, shared with the transmitter.
- Sub-module `sync_2ff`: a 2-flop synchroniser with a parameterised reset value (here 1). It is reused by other asynchronous peripheral inputs.
- The rest is a single FSM with one `always_ff` for state and datapath and one `always_comb` for next-state logic. Target size ≈150–200 lines.

## Test plan
All scenarios use `CLKS_PER_BIT=16`.
- Byte 8'hA5 sent 8N1 ideal → `rx_data_o=8'hA5`, `rx_pulse_o` high exactly 1 cycle, 154 clocks after the falling edge; `frame_err_o` stays 0.
- 8'h00 then 8'hFF back-to-back, no idle gap → two pulses 160 clocks apart, with data 00 then FF.
- Low glitch of 5 clocks on idle line → no strobe; `busy_o` high then low; `rx_data_o` unchanged.
- Frame 8'h3C with stop bit held low, line stays low 40 more bit times → single `frame_err_o` pulse, `rx_data_o` keeps its previous value, `busy_o` stays high until the line returns high, then a following 8'h55 frame is received correctly.
- `rst_i` asserted during data bit 4 of a frame → outputs at reset values on the next edge, no strobe; the next clean frame 8'h81 is received correctly.
- Sender at +3 % baud (bit = 15.5 clocks average) sending 8'hC3 → `rx_data_o=8'hC3`, no frame error.
